multicycle_controller: RTL and testbench

Multicycle successor to the single-cycle main decoder for the RV32 core. It sequences each instruction through fetch, decode, execute, memory and writeback states over one shared memory port, and drives the datapath control strobes. Memory accesses use a request/ready handshake, so wait states are supported. A parametrised retired-instruction counter is included.

---
 rtl/mctrl_pkg.sv | 41 ++++
 rtl/mctrl_imm_decode.sv | 22 ++
 rtl/multicycle_controller.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mctrl_pkg.sv
// Shared encodings and state type for the multicycle RV32 controller.
// Imported by mctrl_imm_decode and multicycle_controller.
package mctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_SUB     = 3'b001;
    localparam logic [2:0] ALU_SPECIAL = 3'b111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, LUI_WB, TRAP
    } state_t;

endpackage

// File: rtl/mctrl_imm_decode.sv
// Opcode to immediate-format select for the multicycle controller.
// Purely combinational; unknown opcodes fall back to the I format.
module mctrl_imm_decode
    import mctrl_pkg::*;
#(
    parameter int IMM_SRC_W = 3
) (
    input  logic [6:0]           opcode,
    output logic [IMM_SRC_W-1:0] imm_src
);

    always_comb begin
        unique case (opcode)
            OP_STORE:  imm_src = IMM_SRC_W'(IMM_S);
            OP_BRANCH: imm_src = IMM_SRC_W'(IMM_B);
            OP_JAL:    imm_src = IMM_SRC_W'(IMM_J);
            OP_LUI:    imm_src = IMM_SRC_W'(IMM_U);
            default:   imm_src = IMM_SRC_W'(IMM_I);
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM with shared memory port and retire counter.
// Define MCTRL_ILLEGAL_TRAP_EN to trap unknown opcodes instead of skipping them.
module multicycle_controller
    import mctrl_pkg::*;
#(
    parameter int ALU_OP_W  = 3,
    parameter int IMM_SRC_W = 3,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 alu_zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_update,
    output logic                 reg_write,
    output logic [IMM_SRC_W-1:0] imm_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [1:0]           result_src,
    output logic [CNT_W-1:0]     instret,
    output logic                 illegal
);

    state_t state, state_nxt;
    logic   retire;
    logic   unused_funct3;

    logic                mreq_c, mwr_c, adr_c, irw_c, pcu_c, rw_c;
    logic [1:0]          srca_c, srcb_c, res_c;
    logic [ALU_OP_W-1:0] aop_c;
    logic [IMM_SRC_W-1:0] imm_dec;

    assign unused_funct3 = ^funct3[2:1];

    mctrl_imm_decode #(.IMM_SRC_W(IMM_SRC_W)) u_imm (
        .opcode  (opcode),
        .imm_src (imm_dec)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH:    if (mem_ready) state_nxt = DECODE;
            DECODE: begin
                unique case (opcode)
                    OP_LOAD,
                    OP_STORE:  state_nxt = MEMADR;
                    OP_RTYPE:  state_nxt = EXEC_R;
                    OP_ITYPE:  state_nxt = EXEC_I;
                    OP_BRANCH: state_nxt = BRANCH;
                    OP_JAL:    state_nxt = JAL;
                    OP_LUI:    state_nxt = LUI_WB;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    default:   state_nxt = TRAP;
`else
                    default:   state_nxt = FETCH;
`endif
                endcase
            end
            MEMADR:   state_nxt = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) state_nxt = MEMWB;
            MEMWB:    state_nxt = FETCH;
            MEMWRITE: if (mem_ready) state_nxt = FETCH;
            EXEC_R,
            EXEC_I:   state_nxt = ALUWB;
            ALUWB:    state_nxt = FETCH;
            BRANCH:   state_nxt = FETCH;
            JAL:      state_nxt = ALUWB;
            LUI_WB:   state_nxt = FETCH;
            TRAP:     state_nxt = TRAP;
            default:  state_nxt = FETCH;
        endcase
    end

    // An undecodable opcode leaves DECODE straight for FETCH and is not retired
    assign retire = (state_nxt == FETCH) && (state != FETCH) && (state != DECODE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            state <= state_nxt;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        mreq_c = 1'b0;
        mwr_c  = 1'b0;
        adr_c  = 1'b0;
        irw_c  = 1'b0;
        pcu_c  = 1'b0;
        rw_c   = 1'b0;
        srca_c = SRCA_PC;
        srcb_c = SRCB_RS2;
        aop_c  = ALU_OP_W'(ALU_ADD);
        res_c  = RES_ALUOUT;
        unique case (state)
            FETCH: begin
                mreq_c = 1'b1;
                irw_c  = mem_ready;
                pcu_c  = mem_ready;
                srcb_c = SRCB_FOUR;
                res_c  = RES_ALU;
            end
            DECODE: begin
                srca_c = SRCA_OLDPC;
                srcb_c = SRCB_IMM;
            end
            MEMADR: begin
                srca_c = SRCA_RS1;
                srcb_c = SRCB_IMM;
            end
            MEMREAD: begin
                mreq_c = 1'b1;
                adr_c  = 1'b1;
            end
            MEMWB: begin
                res_c = RES_MEM;
                rw_c  = 1'b1;
            end
            MEMWRITE: begin
                mreq_c = 1'b1;
                mwr_c  = 1'b1;
                adr_c  = 1'b1;
            end
            EXEC_R: begin
                srca_c = SRCA_RS1;
                aop_c  = ALU_OP_W'(ALU_SPECIAL);
            end
            EXEC_I: begin
                srca_c = SRCA_RS1;
                srcb_c = SRCB_IMM;
                aop_c  = ALU_OP_W'(ALU_SPECIAL);
            end
            ALUWB:  rw_c = 1'b1;
            BRANCH: begin
                srca_c = SRCA_RS1;
                aop_c  = ALU_OP_W'(ALU_SUB);
                pcu_c  = alu_zero ^ funct3[0];
            end
            JAL: begin
                srca_c = SRCA_OLDPC;
                srcb_c = SRCB_FOUR;
                pcu_c  = 1'b1;
            end
            LUI_WB: begin
                res_c = RES_IMM;
                rw_c  = 1'b1;
            end
            default: ;
        endcase
    end

    // Everything is held low while reset is asserted, even mid-access
    assign mem_req    = rst_n & mreq_c;
    assign mem_write  = rst_n & mwr_c;
    assign adr_src    = rst_n & adr_c;
    assign ir_write   = rst_n & irw_c;
    assign pc_update  = rst_n & pcu_c;
    assign reg_write  = rst_n & rw_c;
    assign alu_src_a  = rst_n ? srca_c : '0;
    assign alu_src_b  = rst_n ? srcb_c : '0;
    assign alu_op     = rst_n ? aop_c : '0;
    assign result_src = rst_n ? res_c : '0;
    assign imm_src    = rst_n ? imm_dec : '0;

`ifdef MCTRL_ILLEGAL_TRAP_EN
    assign illegal = rst_n && (state == TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: vector table, random
// instruction stream against a phase-sequence model, and reset corners.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_req, mem_write, adr_src, ir_write, pc_update, reg_write;
    logic [2:0]  imm_src;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  alu_op;
    logic [31:0] instret;
    logic        illegal;
    logic [18:0] act;

    int total = 0;
    int bad = 0;
    int retired = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_update  (pc_update),
        .reg_write  (reg_write),
        .imm_src    (imm_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .instret    (instret),
        .illegal    (illegal)
    );

    assign act = {illegal, mem_req, mem_write, adr_src, ir_write, pc_update,
                  reg_write, alu_src_a, alu_src_b, alu_op, result_src, imm_src};

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b1101111: return 3'd3;
            7'b0110111: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111, 7'b0110111};
    endfunction

    // Expected outputs for one cycle of a named instruction phase
    function automatic logic [18:0] expect_ph(input string ph, input bit rdy,
                                              input logic az, input logic [2:0] f3,
                                              input logic [6:0] op);
        logic mreq = 0, mw = 0, adr = 0, irw = 0, pcu = 0, rw = 0;
        logic [1:0] a = 0, b = 0, rs = 0;
        logic [2:0] aop = 0;
        case (ph)
            "F":   begin mreq = 1; irw = rdy; pcu = rdy; b = 2; rs = 2; end
            "D":   begin a = 1; b = 1; end
            "MA":  begin a = 2; b = 1; end
            "MR":  begin mreq = 1; adr = 1; end
            "MWB": begin rs = 1; rw = 1; end
            "MW":  begin mreq = 1; mw = 1; adr = 1; end
            "XR":  begin a = 2; aop = 7; end
            "XI":  begin a = 2; b = 1; aop = 7; end
            "AWB": begin rw = 1; end
            "BR":  begin a = 2; aop = 1; pcu = az ^ f3[0]; end
            "J":   begin a = 1; b = 2; pcu = 1; end
            "L":   begin rs = 3; rw = 1; end
            default: ;
        endcase
        return {1'b0, mreq, mw, adr, irw, pcu, rw, a, b, aop, rs, imm_of(op)};
    endfunction

    typedef struct {
        string ph;
        bit    rdy;
    } cyc_t;

    cyc_t q[$];

    task automatic push(input string ph, input bit rdy);
        cyc_t c;
        c.ph = ph;
        c.rdy = rdy;
        q.push_back(c);
    endtask

    task automatic push_wait(input string ph, input int w);
        for (int i = 0; i < w; i++) push(ph, 1'b0);
        push(ph, 1'b1);
    endtask

    // Instruction as a list of phases; noise on ready where it is ignored
    task automatic build(input logic [6:0] op, input int fw, input int mw);
        q.delete();
        push_wait("F", fw);
        push("D", 1'($urandom % 2));
        case (op)
            7'b0000011: begin
                push("MA", 1'($urandom % 2));
                push_wait("MR", mw);
                push("MWB", 1'($urandom % 2));
            end
            7'b0100011: begin
                push("MA", 1'($urandom % 2));
                push_wait("MW", mw);
            end
            7'b0110011: begin push("XR", 1'($urandom % 2)); push("AWB", 1'($urandom % 2)); end
            7'b0010011: begin push("XI", 1'($urandom % 2)); push("AWB", 1'($urandom % 2)); end
            7'b1100011: push("BR", 1'($urandom % 2));
            7'b1101111: begin push("J", 1'($urandom % 2)); push("AWB", 1'($urandom % 2)); end
            7'b0110111: push("L", 1'($urandom % 2));
            default: ;
        endcase
    endtask

    task automatic run_model(input int n, input logic [6:0] op, input logic [2:0] f3,
                             input logic az, input int fw, input int mw);
        build(op, fw, mw);
        opcode = op;
        funct3 = f3;
        alu_zero = az;
        foreach (q[i]) begin
            mem_ready = q[i].rdy;
            #1;
            chk($sformatf("rnd%0d op=%b %s.%0d", n, op, q[i].ph, i), act,
                expect_ph(q[i].ph, q[i].rdy, az, f3, op));
            @(negedge clk);
            #1;
        end
        if (is_legal(op)) retired++;
        chk($sformatf("rnd%0d instret", n), instret, retired);
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       az;
        int         fw;
        int         mwait;
        int         cyc;
        int         ret;
        int         nrw;
        int         npcu;
        int         nmw;
    } vec_t;

    vec_t vt[14];

    // Drives ready reactively from the request and counts strobes until the next fetch
    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0, rw = 0, pcu = 0, mw = 0;
        int fwc = v.fw, mwc = v.mwait;
        bit seen = 0;
        opcode = v.op;
        funct3 = v.f3;
        alu_zero = v.az;
        while (cyc < 40) begin
            if (seen && mem_req && !adr_src) break;
            if (mem_req && !adr_src && fwc > 0) begin
                mem_ready = 1'b0;
                fwc--;
            end else if (mem_req && adr_src && mwc > 0) begin
                mem_ready = 1'b0;
                mwc--;
            end else if (mem_req) begin
                mem_ready = 1'b1;
            end else begin
                mem_ready = 1'($urandom % 2);
            end
            #1;
            if (ir_write) seen = 1;
            rw += int'(reg_write);
            pcu += int'(pc_update);
            mw += int'(mem_write & mem_req);
            cyc++;
            @(negedge clk);
            #1;
        end
        retired += v.ret;
        chk($sformatf("vec%0d cycles", idx), cyc, v.cyc);
        chk($sformatf("vec%0d reg_write", idx), rw, v.nrw);
        chk($sformatf("vec%0d pc_update", idx), pcu, v.npcu);
        chk($sformatf("vec%0d mem_write", idx), mw, v.nmw);
        chk($sformatf("vec%0d instret", idx), instret, retired);
    endtask

    initial begin
        logic [6:0] ops[8];
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        ops[6] = 7'b0110111; ops[7] = 7'b1111111;

        vt[0]  = '{7'b0110011, 3'd0, 1'b0, 0, 0, 4, 1, 1, 1, 0};
        vt[1]  = '{7'b0010011, 3'd0, 1'b0, 1, 0, 5, 1, 1, 1, 0};
        vt[2]  = '{7'b0000011, 3'd2, 1'b0, 0, 2, 7, 1, 1, 1, 0};
        vt[3]  = '{7'b0000011, 3'd2, 1'b1, 0, 0, 5, 1, 1, 1, 0};
        vt[4]  = '{7'b0100011, 3'd2, 1'b0, 0, 1, 5, 1, 0, 1, 2};
        vt[5]  = '{7'b0100011, 3'd2, 1'b0, 2, 0, 6, 1, 0, 1, 1};
        vt[6]  = '{7'b1100011, 3'd1, 1'b0, 0, 0, 3, 1, 0, 2, 0};
        vt[7]  = '{7'b1100011, 3'd1, 1'b1, 0, 0, 3, 1, 0, 1, 0};
        vt[8]  = '{7'b1100011, 3'd0, 1'b1, 0, 0, 3, 1, 0, 2, 0};
        vt[9]  = '{7'b1100011, 3'd0, 1'b0, 0, 0, 3, 1, 0, 1, 0};
        vt[10] = '{7'b1101111, 3'd0, 1'b0, 0, 0, 4, 1, 1, 2, 0};
        vt[11] = '{7'b0110111, 3'd0, 1'b0, 0, 0, 3, 1, 1, 1, 0};
        vt[12] = '{7'b0110111, 3'd0, 1'b0, 2, 0, 5, 1, 1, 1, 0};
        vt[13] = '{7'b1111111, 3'd0, 1'b0, 0, 0, 2, 0, 0, 1, 0};

        @(negedge clk);
        #1;
        chk("rst_strobes", {mem_req, mem_write, ir_write, pc_update, reg_write}, 0);
        chk("rst_ctrl", {adr_src, alu_src_a, alu_src_b, alu_op, result_src}, 0);
        chk("rst_instret", instret, 0);
        chk("rst_illegal", illegal, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_fetch", {mem_req, adr_src, mem_write}, 3'b100);

        foreach (vt[i]) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
            if (vt[i].ret == 0) continue;
`endif
            run_vec(vt[i], i);
        end

        for (int n = 0; n < 150; n++) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
            int k = int'($urandom % 7);
`else
            int k = int'($urandom % 8);
`endif
            run_model(n, ops[k], 3'($urandom), 1'($urandom % 2),
                      int'($urandom % 3), int'($urandom % 3));
        end

        // Reset in the middle of a stalled store
        opcode = 7'b0100011;
        mem_ready = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        mem_ready = 1'b0;
        #1;
        chk("store_strobe", {mem_req, mem_write, adr_src}, 3'b111);
        rst_n = 1'b0;
        #1;
        retired = 0;
        chk("midrst_strobes", {mem_req, mem_write, reg_write, pc_update}, 0);
        chk("midrst_instret", instret, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_fetch", {mem_req, adr_src, mem_write}, 3'b100);

`ifdef MCTRL_ILLEGAL_TRAP_EN
        opcode = 7'b1111111;
        mem_ready = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'($urandom % 2);
            #1;
            chk($sformatf("trap%0d", i),
                {illegal, mem_req, ir_write, pc_update, reg_write, mem_write}, 6'b100000);
            @(negedge clk); #1;
        end
        chk("trap_instret", instret, retired);
        rst_n = 1'b0;
        #1;
        chk("trap_rst", illegal, 0);
        rst_n = 1'b1;
`else
        run_vec(vt[13], 99);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
